// File: rtl/load_split_ctrl.sv
// load_split_ctrl: sequences a load into one or two dword-aligned cache reads,
// steers the memory-data register strobes (whole, edge or partial fill), and
// reports completion, misalignment and cache-stall timeouts.
module load_split_ctrl #(
   parameter int ADDR_WIDTH = 64,
   parameter int TIMEOUT    = 256,
   parameter int CNT_WIDTH  = 9
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [1:0]            i_size,
   output logic                  o_busy,
   output logic                  o_cache_req,
   output logic [ADDR_WIDTH-1:0] o_cache_addr,
   input  logic                  i_cache_ack,
   output logic                  o_reg_we,
   output logic                  o_edge_ld,
   output logic                  o_partial_ld,
   output logic [2:0]            o_offset,
   output logic                  o_done,
   output logic                  o_fault,
   output logic                  o_fault_code
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACC1  = 3'd1,
      S_ACC2  = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   localparam logic FC_MISALIGN = 1'b0;
   localparam logic FC_TIMEOUT  = 1'b1;

   // A zero TIMEOUT disables the watchdog; the limit value is then unused.
   localparam bit                    WD_EN      = (TIMEOUT != 0);
   localparam logic [CNT_WIDTH-1:0]  WD_LIMIT   = CNT_WIDTH'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] DWORD_STEP = ADDR_WIDTH'(8);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            size_q, size_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  fault_code_q, fault_code_d;

   logic                  misaligned;
   logic                  split;
   logic                  wd_expired;
   logic [ADDR_WIDTH-1:0] base_addr;

   // Classify the incoming request; only consulted when accepting in IDLE.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path through the case can leave it unassigned (latch).
      misaligned = 1'b0;
      case (i_size)
         SZ_HALF:           misaligned = i_addr[0];
         SZ_WORD, SZ_DWORD: misaligned = (i_addr[1:0] != 2'b00);
         default:           misaligned = 1'b0;
      endcase
   end

   // A 4-byte-aligned dword starting in the upper half of a dword straddles
   // two aligned dwords and needs a second access.
   assign split      = (size_q == SZ_DWORD) && addr_q[2];
   assign base_addr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
   assign wd_expired = WD_EN && (cnt_q == WD_LIMIT) && !i_cache_ack;

   // Next-state, latched-request and watchdog computation.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      cnt_d        = cnt_q;
      fault_code_d = fault_code_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               addr_d = i_addr;
               size_d = i_size;
               cnt_d  = '0;
               if (misaligned) begin
                  fault_code_d = FC_MISALIGN;
                  state_d      = S_FAULT;
               end else begin
                  state_d = S_ACC1;
               end
            end
         end
         S_ACC1: begin
            if (i_cache_ack) begin
               cnt_d   = '0;
               state_d = split ? S_ACC2 : S_DONE;
            end else if (wd_expired) begin
               fault_code_d = FC_TIMEOUT;
               state_d      = S_FAULT;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         S_ACC2: begin
            if (i_cache_ack) begin
               state_d = S_DONE;
            end else if (wd_expired) begin
               fault_code_d = FC_TIMEOUT;
               state_d      = S_FAULT;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched-request registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         size_q       <= '0;
         cnt_q        <= '0;
         fault_code_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // present before the edge, independent of statement order.
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         cnt_q        <= cnt_d;
         fault_code_q <= fault_code_d;
      end
   end

   // Cache address: aligned dword for the first access, next dword (wrapping)
   // for the second, zero while no request is outstanding.
   always_comb begin
      o_cache_addr = '0;
      case (state_q)
         S_ACC1:  o_cache_addr = base_addr;
         S_ACC2:  o_cache_addr = base_addr + DWORD_STEP;
         default: o_cache_addr = '0;
      endcase
   end

   // Status outputs decode the registered state; register strobes follow the
   // ack combinationally and only inside an access state.
   assign o_busy       = (state_q != S_IDLE);
   assign o_cache_req  = (state_q == S_ACC1) || (state_q == S_ACC2);
   assign o_reg_we     = o_cache_req && i_cache_ack;
   assign o_edge_ld    = (state_q == S_ACC1) && i_cache_ack && split;
   assign o_partial_ld = (state_q == S_ACC2) && i_cache_ack;
   assign o_offset     = split ? 3'b000 : addr_q[2:0];
   assign o_done       = (state_q == S_DONE);
   assign o_fault      = (state_q == S_FAULT);
   assign o_fault_code = (state_q == S_FAULT) && fault_code_q;

endmodule

// File: tb/tb_load_split_ctrl.sv
// tb_load_split_ctrl: directed loads with hand-computed expectations pushed
// into per-kind queues; a negedge monitor pops and compares DUT responses.
module tb_load_split_ctrl;

   localparam int AW  = 64;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          arstn;
   logic          i_start;
   logic [AW-1:0] i_addr;
   logic [1:0]    i_size;
   logic          o_busy;
   logic          o_cache_req;
   logic [AW-1:0] o_cache_addr;
   logic          i_cache_ack;
   logic          o_reg_we;
   logic          o_edge_ld;
   logic          o_partial_ld;
   logic [2:0]    o_offset;
   logic          o_done;
   logic          o_fault;
   logic          o_fault_code;

   load_split_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .CNT_WIDTH(9)) dut (
      .clk          (clk),
      .arstn        (arstn),
      .i_start      (i_start),
      .i_addr       (i_addr),
      .i_size       (i_size),
      .o_busy       (o_busy),
      .o_cache_req  (o_cache_req),
      .o_cache_addr (o_cache_addr),
      .i_cache_ack  (i_cache_ack),
      .o_reg_we     (o_reg_we),
      .o_edge_ld    (o_edge_ld),
      .o_partial_ld (o_partial_ld),
      .o_offset     (o_offset),
      .o_done       (o_done),
      .o_fault      (o_fault),
      .o_fault_code (o_fault_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      int            len;
   } req_t;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic          edg;
      logic          part;
   } we_t;

   typedef struct {
      int         cyc;
      logic       fault;
      logic       code;
      logic [2:0] off;
   } end_t;

   typedef struct {
      string         name;
      logic [AW-1:0] addr;
      logic [1:0]    size;
      int            w1;     // wait cycles before ack in ACC1 (>=TMO: never)
      int            w2;     // same for ACC2
      bit            mis;
      bit            split;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [2:0]    off;
      bit            poke;   // pulse i_start during ACC1
   } vec_t;

   req_t req_q[$];
   we_t  we_q[$];
   end_t end_q[$];
   vec_t vecs[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},    o_busy,       0);
      check({tag, "_req"},     o_cache_req,  0);
      check({tag, "_addr"},    o_cache_addr, 0);
      check({tag, "_we"},      o_reg_we,     0);
      check({tag, "_edge"},    o_edge_ld,    0);
      check({tag, "_partial"}, o_partial_ld, 0);
      check({tag, "_offset"},  o_offset,     0);
      check({tag, "_done"},    o_done,       0);
      check({tag, "_fault"},   o_fault,      0);
      check({tag, "_code"},    o_fault_code, 0);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ack();
      i_cache_ack = 1'b1;
      @(posedge clk);
      #1;
      i_cache_ack = 1'b0;
   endtask

   // Push the expected responses of one load, then drive it.
   task automatic do_load(input vec_t v);
      int t0;
      int c;
      int skip;
      @(posedge clk);
      #1;
      t0   = cyc;
      skip = 0;
      if (v.mis) begin
         end_q.push_back('{t0 + 1, 1'b1, 1'b0, 3'd0});
      end else begin
         c = t0 + 1;
         if (v.w1 >= TMO) begin
            req_q.push_back('{v.a1, TMO});
            end_q.push_back('{c + TMO, 1'b1, 1'b1, 3'd0});
         end else begin
            req_q.push_back('{v.a1, v.w1 + 1});
            c += v.w1;
            we_q.push_back('{c, v.a1, v.split, 1'b0});
            if (v.split) begin
               c += 1;
               if (v.w2 >= TMO) begin
                  req_q.push_back('{v.a2, TMO});
                  end_q.push_back('{c + TMO, 1'b1, 1'b1, 3'd0});
               end else begin
                  req_q.push_back('{v.a2, v.w2 + 1});
                  c += v.w2;
                  we_q.push_back('{c, v.a2, 1'b0, 1'b1});
                  end_q.push_back('{c + 1, 1'b0, 1'b0, v.off});
               end
            end else begin
               end_q.push_back('{c + 1, 1'b0, 1'b0, v.off});
            end
         end
      end
      i_start = 1'b1;
      i_addr  = v.addr;
      i_size  = v.size;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (v.poke) begin
         i_start = 1'b1;
         i_addr  = 64'h11;
         i_size  = 2'd1;
         @(posedge clk);
         #1;
         i_start = 1'b0;
         skip    = 1;
      end
      if (!v.mis) begin
         if (v.w1 >= TMO) begin
            wait_cycles(TMO - skip);
         end else begin
            wait_cycles(v.w1 - skip);
            pulse_ack();
            if (v.split) begin
               if (v.w2 >= TMO) wait_cycles(TMO);
               else begin
                  wait_cycles(v.w2);
                  pulse_ack();
               end
            end
         end
      end
      wait_cycles(2);
   endtask

   // Monitor: request runs, register writes and completions are popped from
   // their queues and compared as the DUT presents them.
   initial begin
      logic          run_on;
      logic [AW-1:0] run_addr;
      int            run_len;
      req_t          r;
      we_t           w;
      end_t          e;
      run_on   = 1'b0;
      run_addr = '0;
      run_len  = 0;
      forever begin
         @(negedge clk);
         if (run_on && !(o_cache_req && o_cache_addr == run_addr)) begin
            check("req_expected", req_q.size() != 0, 1);
            if (req_q.size() != 0) begin
               r = req_q.pop_front();
               check("req_addr", run_addr, r.addr);
               check("req_len", run_len, r.len);
            end
            run_on = 1'b0;
         end
         if (o_cache_req) begin
            if (run_on) run_len++;
            else begin
               run_on   = 1'b1;
               run_addr = o_cache_addr;
               run_len  = 1;
            end
         end
         check("strobe_excl", (o_edge_ld & o_partial_ld) | ((o_edge_ld | o_partial_ld) & ~o_reg_we), 0);
         if (o_reg_we) begin
            check("we_expected", we_q.size() != 0, 1);
            if (we_q.size() != 0) begin
               w = we_q.pop_front();
               check("we_cycle", cyc, w.cyc);
               check("we_addr", o_cache_addr, w.addr);
               check("we_edge", o_edge_ld, w.edg);
               check("we_partial", o_partial_ld, w.part);
            end
         end
         if (o_done || o_fault) begin
            check("end_expected", end_q.size() != 0, 1);
            if (end_q.size() != 0) begin
               e = end_q.pop_front();
               check("end_cycle", cyc, e.cyc);
               check("end_kind", {o_fault, o_done}, {e.fault, ~e.fault});
               check("end_busy", o_busy, 1);
               if (e.fault) check("fault_code", o_fault_code, e.code);
               else         check("done_offset", o_offset, e.off);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      arstn       = 1'b0;
      i_start     = 1'b0;
      i_addr      = '0;
      i_size      = 2'd0;
      i_cache_ack = 1'b0;

      //                  name          addr                    sz  w1 w2 mis spl a1                      a2                     off poke
      vecs.push_back(vec_t'{"word",      64'h1004,               2'd2, 1, 0, 0, 0, 64'h1000,               64'h0,                3'd4, 0});
      vecs.push_back(vec_t'{"split",     64'h2004,               2'd3, 0, 0, 0, 1, 64'h2000,               64'h2008,             3'd0, 0});
      vecs.push_back(vec_t'{"wrap",      64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                3'd0, 0});
      vecs.push_back(vec_t'{"mis_half",  64'h11,                 2'd1, 0, 0, 1, 0, 64'h0,                  64'h0,                3'd0, 0});
      vecs.push_back(vec_t'{"mis_word",  64'h102,                2'd2, 0, 0, 1, 0, 64'h0,                  64'h0,                3'd0, 0});
      vecs.push_back(vec_t'{"mis_dword", 64'h206,                2'd3, 0, 0, 1, 0, 64'h0,                  64'h0,                3'd0, 0});
      vecs.push_back(vec_t'{"timeout",   64'h3000,               2'd2, 4, 0, 0, 0, 64'h3000,               64'h0,                3'd0, 0});
      vecs.push_back(vec_t'{"ack_limit", 64'h3008,               2'd3, 3, 0, 0, 0, 64'h3008,               64'h0,                3'd0, 0});
      vecs.push_back(vec_t'{"byte",      64'h4007,               2'd0, 0, 0, 0, 0, 64'h4000,               64'h0,                3'd7, 0});
      vecs.push_back(vec_t'{"half",      64'h5006,               2'd1, 2, 0, 0, 0, 64'h5000,               64'h0,                3'd6, 0});
      vecs.push_back(vec_t'{"split_wait",64'h6004,               2'd3, 2, 3, 0, 1, 64'h6000,               64'h6008,             3'd0, 0});
      vecs.push_back(vec_t'{"acc2_tmo",  64'h6104,               2'd3, 0, 4, 0, 1, 64'h6100,               64'h6108,             3'd0, 0});
      vecs.push_back(vec_t'{"poke_acc1", 64'h7014,               2'd2, 2, 0, 0, 0, 64'h7010,               64'h0,                3'd4, 1});

      repeat (2) @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;
      arstn = 1'b1;

      foreach (vecs[i]) do_load(vecs[i]);

      // Stray ack while idle must not produce any strobe.
      @(posedge clk);
      #1;
      i_cache_ack = 1'b1;
      @(negedge clk);
      check("stray_we",      o_reg_we,     0);
      check("stray_edge",    o_edge_ld,    0);
      check("stray_partial", o_partial_ld, 0);
      check("stray_busy",    o_busy,       0);
      @(posedge clk);
      #1;
      i_cache_ack = 1'b0;
      wait_cycles(2);

      // Reset during ACC2 of a split load: first access completes, the second
      // request is cut after one cycle, and no completion follows.
      @(posedge clk);
      #1;
      req_q.push_back('{64'h7000, 1});
      we_q.push_back('{cyc + 1, 64'h7000, 1'b1, 1'b0});
      req_q.push_back('{64'h7008, 1});
      i_start = 1'b1;
      i_addr  = 64'h7004;
      i_size  = 2'd3;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      pulse_ack();
      @(posedge clk);
      #1;
      arstn = 1'b0;
      @(negedge clk);
      check_zero("rst_acc2");
      @(posedge clk);
      #1;
      arstn = 1'b1;
      wait_cycles(1);

      v = vec_t'{"after_rst", 64'h8004, 2'd3, 1, 0, 0, 1, 64'h8000, 64'h8008, 3'd0, 0};
      do_load(v);
      wait_cycles(3);

      check("req_q_drained", req_q.size(), 0);
      check("we_q_drained",  we_q.size(),  0);
      check("end_q_drained", end_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
